song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Parametrised song player for the keyboard's auto-play path. Holds NUM_SONGS note/duration
//  tables and steps through the selected one, presenting each note for its duration in clk cycles.
//  Adds start/stop/pause control, looping and an end-of-song pulse. Feeds the tone generator.
// PARAMETERS
//  NUM_SONGS   4        number of song tables; SEL_W = $clog2(NUM_SONGS)
//  MAX_NOTES   64       entries per song; IDX_W = $clog2(MAX_NOTES)
//  NOTE_W      4        note code width; code 0 = rest (silence)
//  DUR_W       32       duration width, in clk cycles
//  GAP_CYCLES  100_000  silence between notes (only with SONG_GAP_EN)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       level, sampled in IDLE: begin playing song_sel
//  stop        in   1       abort playback; return to IDLE
//  pause       in   1       level; while high, hold position and output rest
//  loop_en     in   1       sampled at end of song: 1 = restart at entry 0
//  song_sel    in   SEL_W   song index, latched on accepted start
//  note        out  NOTE_W  current note code (0 when not sounding)
//  note_valid  out  1       high while a table note is being presented (incl. rest codes)
//  note_on     out  1       1-cycle pulse on the first cycle of each new entry
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse when a non-looping song ends
//  cur_idx     out  IDX_W   index of the entry being presented
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched song 0, counters 0.
//  States: IDLE, FETCH, PLAY, PAUSED (plus GAP with SONG_GAP_EN).
//  IDLE: start && !stop -> latch song_sel, cur_idx=0 -> FETCH. start outside IDLE is ignored.
//  FETCH: one cycle, registered table read; only at song start (and loop restart).
//  Latency: start high at cycle N -> note/note_on valid at N+2.
//  PLAY: note held exactly dur cycles; next entry appears the following cycle
//   (prefetch of idx+1 during PLAY, no bubble between notes).
//  End of song: entry with dur==0, or idx==MAX_NOTES-1 completing. The dur==0 entry is never presented.
//   loop_en=1 -> FETCH idx 0, no done. loop_en=0 -> done pulse, note=0, -> IDLE.
//  Out-of-range song_sel (>= NUM_SONGS): done pulses on cycle after start; no notes presented.
//  pause=1 in PLAY/GAP -> PAUSED: duration counter frozen, note=0, note_valid=0, note_on=0.
//   pause=0 -> resume the same state with the remaining count. No note_on on resume.
//  stop: from any state -> IDLE next cycle, note/note_valid cleared, no done.
//   Priority: stop > pause > duration expiry. start && stop in IDLE: stay IDLE.
//  Counter: down-counter loaded with dur-1; expiry at 0. dur==1 gives a one-cycle note.
//  Async reset mid-song: immediate return to reset values; no done.
// CONFIGURATION
//  SONG_GAP_EN defined: after every note except the last, GAP state for GAP_CYCLES cycles.
//   In GAP: note=0, note_valid=0. Pause and stop apply as in PLAY.
//  SONG_GAP_EN undefined: notes are back to back; GAP state and GAP_CYCLES logic absent.
// STRUCTURE
//  song_pkg: state enum, NOTE_REST=0, default widths, end-marker constant DUR_END=0.
//  Sub-module song_table_rom: registered read of {song, idx} -> {note, dur}.
//   Tables are initialised from case constants. The sequencer holds the FSM and counter only.
// TESTING
//  1. Song 0 with entries (1,3),(5,2),(0-end): start -> note 1 for 3 cyc, note 5 for 2 cyc.
//     note_on pulses at N+2 and N+5; done at N+7; busy low at N+8.
//  2. loop_en=1 on same song: after the last note, FETCH then note 1 again. No done.
//     Drop loop_en -> done after the next pass.
//  3. pause 4 cycles mid note of dur 10 after 3 cycles: note=0 during pause.
//     Note 1 resumes for exactly 7 more cycles.
//  4. stop asserted with pause in PLAY: IDLE next cycle, note=0, done stays 0.
//     Start in the same cycle as stop: no playback.
//  5. song_sel=NUM_SONGS: done one cycle after start, note_valid never high.
//     rst_n low mid-note: outputs 0 asynchronously.
//  6. SONG_GAP_EN, GAP_CYCLES=2, test 1 table: note 1 x3, rest x2, note 5 x2, no gap after the last note.

Source files
------------

// File: rtl/song_pkg.sv
// Shared types and constants for the song player.
// Build option: SONG_GAP_EN adds the inter-note GAP state.
package song_pkg;

`ifdef SONG_GAP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_GAP    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;
`endif

    localparam int DEF_NOTE_W = 4;
    localparam int DEF_DUR_W  = 32;
    // Note code that means silence.
    localparam int NOTE_REST  = 0;
    // A table entry with this duration marks the end of a song.
    localparam int DUR_END    = 0;

endpackage

// File: rtl/song_table_rom.sv
// Constant song tables with a registered read port: {song, idx} -> {note, dur}.
// Unlisted entries read as the end marker (rest, duration 0).
module song_table_rom
    import song_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int IDX_W  = 6,
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W
) (
    input  logic              clk,
    input  logic [SEL_W-1:0]  i_song,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [NOTE_W-1:0] o_note,
    output logic [DUR_W-1:0]  o_dur
);

    function automatic logic [NOTE_W+DUR_W-1:0] ent(input int n, input int d);
        return {NOTE_W'(n), DUR_W'(d)};
    endfunction

    function automatic logic [NOTE_W+DUR_W-1:0] lookup(input int s, input int i);
        logic [NOTE_W+DUR_W-1:0] e;
        e = ent(NOTE_REST, DUR_END);
        case (s)
            0: case (i)
                0: e = ent(1, 3);
                1: e = ent(5, 2);
                default: ;
            endcase
            1: case (i)
                0: e = ent(1, 10);
                1: e = ent(0, 2);
                2: e = ent(3, 1);
                default: ;
            endcase
            2: case (i)
                0: e = ent(7, 1);
                1: e = ent(8, 1);
                2: e = ent(9, 1);
                default: ;
            endcase
            3: case (i)
                0: e = ent(2, 4);
                1: e = ent(4, 4);
                default: ;
            endcase
            default: ;
        endcase
        return e;
    endfunction

    // Registered table read; pure data, so no reset.
    always_ff @(posedge clk) begin
        {o_note, o_dur} <= lookup(int'(i_song), int'(i_idx));
    end

endmodule

// File: rtl/song_sequencer.sv
// Song player: steps through the selected table, holding each note for its
// duration, with start/stop/pause, looping and an end-of-song pulse.
// Build option: SONG_GAP_EN inserts GAP_CYCLES of silence between notes.
module song_sequencer
    import song_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int MAX_NOTES  = 64,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
`ifdef SONG_GAP_EN
    parameter int GAP_CYCLES = 100_000,
`endif
    localparam int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int IDX_W     = $clog2(MAX_NOTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [SEL_W-1:0]  song_sel,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              note_on,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_NOTES - 1);
    localparam logic [SEL_W:0]    SONGS_L  = (SEL_W + 1)'(NUM_SONGS);
    localparam logic [NOTE_W-1:0] REST_L   = NOTE_W'(NOTE_REST);
    localparam logic [DUR_W-1:0]  END_L    = DUR_W'(DUR_END);
`ifdef SONG_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GAP_W-1:0] r_gcnt, w_nxt_gcnt;
`endif

    state_t            r_state, r_res, w_nxt_state, w_nxt_res, w_st;
    logic [SEL_W-1:0]  r_song, w_nxt_song;
    logic [IDX_W-1:0]  r_idx, w_nxt_idx, w_rom_idx;
    logic [DUR_W-1:0]  r_cnt, w_nxt_cnt, w_cnt_cur;
    logic              r_load, w_nxt_load;   // current ROM output is an entry still to be started
    logic              r_eos, w_nxt_eos;     // last table slot consumed; next load ends the song
    logic              r_hold, w_nxt_hold;   // pending entry parked in r_held_* during a pause
    logic [NOTE_W-1:0] r_note, r_held_note, w_rom_note, w_ent_note;
    logic [DUR_W-1:0]  r_held_dur, w_rom_dur, w_ent_dur;
    logic              w_cap_note, w_cap_hold, w_end, w_expire;

    // FETCH reads the entry at r_idx; otherwise the next entry is prefetched
    // so consecutive notes follow with no bubble.
    assign w_rom_idx = (r_state == ST_FETCH) ? r_idx : r_idx + 1'b1;

    song_table_rom #(
        .SEL_W  (SEL_W),
        .IDX_W  (IDX_W),
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W)
    ) u_rom (
        .clk    (clk),
        .i_song (r_song),
        .i_idx  (w_rom_idx),
        .o_note (w_rom_note),
        .o_dur  (w_rom_dur)
    );

    // PAUSED behaves as the state it interrupted once pause drops, so resume is seamless.
    assign w_st       = (r_state == ST_PAUSED) ? r_res : r_state;
    assign w_ent_note = r_hold ? r_held_note : w_rom_note;
    assign w_ent_dur  = r_hold ? r_held_dur  : w_rom_dur;
    assign w_end      = r_eos || (w_ent_dur == END_L);
    assign w_cnt_cur  = r_load ? (w_ent_dur - 1'b1) : r_cnt;
    assign w_expire   = (w_cnt_cur == '0);
    assign busy       = (r_state != ST_IDLE);
    assign cur_idx    = r_idx;

    // Next-state, counter and output decode; priority is stop > pause > expiry.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_res   = r_res;
        w_nxt_song  = r_song;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_nxt_load  = r_load;
        w_nxt_eos   = r_eos;
        w_nxt_hold  = r_hold;
`ifdef SONG_GAP_EN
        w_nxt_gcnt  = r_gcnt;
`endif
        w_cap_note  = 1'b0;
        w_cap_hold  = 1'b0;
        note        = REST_L;
        note_valid  = 1'b0;
        note_on     = 1'b0;
        done        = 1'b0;
        if (stop) begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = '0;
            w_nxt_load  = 1'b0;
            w_nxt_eos   = 1'b0;
            w_nxt_hold  = 1'b0;
        end else begin
            case (w_st)
                ST_IDLE: begin
                    if (start) begin
                        w_nxt_song  = song_sel;
                        w_nxt_idx   = '0;
                        w_nxt_load  = 1'b0;
                        w_nxt_eos   = 1'b0;
                        w_nxt_hold  = 1'b0;
                        w_nxt_state = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if ({1'b0, r_song} >= SONGS_L) begin
                        done        = 1'b1;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state = ST_PLAY;
                        w_nxt_load  = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        w_nxt_state = ST_PAUSED;
                        w_nxt_res   = ST_PLAY;
                        if (r_load && !r_hold) begin
                            w_cap_hold = 1'b1;
                            w_nxt_hold = 1'b1;
                        end
                    end else if (r_load && w_end) begin
                        if (loop_en) begin
                            w_nxt_state = ST_FETCH;
                        end else begin
                            done        = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end
                        w_nxt_idx  = '0;
                        w_nxt_load = 1'b0;
                        w_nxt_eos  = 1'b0;
                        w_nxt_hold = 1'b0;
                    end else begin
                        note        = r_load ? w_ent_note : r_note;
                        note_valid  = 1'b1;
                        note_on     = r_load;
                        w_cap_note  = r_load;
                        w_nxt_state = ST_PLAY;
                        w_nxt_load  = 1'b0;
                        w_nxt_hold  = 1'b0;
                        if (w_expire) begin
`ifdef SONG_GAP_EN
                            if (r_idx == LAST_IDX) begin
                                w_nxt_idx  = r_idx + 1'b1;
                                w_nxt_load = 1'b1;
                                w_nxt_eos  = 1'b1;
                            end else begin
                                w_nxt_state = ST_GAP;
                                w_nxt_gcnt  = GAP_W'(GAP_CYCLES - 1);
                            end
`else
                            w_nxt_idx  = r_idx + 1'b1;
                            w_nxt_load = 1'b1;
                            w_nxt_eos  = (r_idx == LAST_IDX);
`endif
                        end else begin
                            w_nxt_cnt = w_cnt_cur - 1'b1;
                        end
                    end
                end
`ifdef SONG_GAP_EN
                // The prefetched next entry is visible here; if it is the end
                // marker the song ends now instead of sitting through a gap.
                ST_GAP: begin
                    if (pause) begin
                        w_nxt_state = ST_PAUSED;
                        w_nxt_res   = ST_GAP;
                    end else if (w_rom_dur == END_L) begin
                        if (loop_en) begin
                            w_nxt_state = ST_FETCH;
                        end else begin
                            done        = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end
                        w_nxt_idx  = '0;
                        w_nxt_load = 1'b0;
                        w_nxt_eos  = 1'b0;
                        w_nxt_hold = 1'b0;
                    end else if (r_gcnt == '0) begin
                        w_nxt_state = ST_PLAY;
                        w_nxt_idx   = r_idx + 1'b1;
                        w_nxt_load  = 1'b1;
                    end else begin
                        w_nxt_state = ST_GAP;
                        w_nxt_gcnt  = r_gcnt - 1'b1;
                    end
                end
`endif
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    // Control state: state, resume target, song, index and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_res   <= ST_IDLE;
            r_song  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_eos   <= 1'b0;
            r_hold  <= 1'b0;
`ifdef SONG_GAP_EN
            r_gcnt  <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_res   <= w_nxt_res;
            r_song  <= w_nxt_song;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_load  <= w_nxt_load;
            r_eos   <= w_nxt_eos;
            r_hold  <= w_nxt_hold;
`ifdef SONG_GAP_EN
            r_gcnt  <= w_nxt_gcnt;
`endif
        end
    end

    // Entry data: note being held, and an entry parked while paused before it started.
    always_ff @(posedge clk) begin
        if (w_cap_note) begin
            r_note <= w_ent_note;
        end
        if (w_cap_hold) begin
            r_held_note <= w_rom_note;
            r_held_dur  <= w_rom_dur;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer. Tables used: song 0 = (1,3),(5,2),end;
// song 1 = (1,10),(0,2),(3,1),end; song 2 = (7,1),(8,1),(9,1),end; song 3 out of range.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic [3:0] note;
    logic       note_valid, note_on, busy, done;
    logic [5:0] cur_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    song_sequencer #(
        .NUM_SONGS  (3),
        .MAX_NOTES  (64),
        .NOTE_W     (4),
        .DUR_W      (32)
`ifdef SONG_GAP_EN
        , .GAP_CYCLES (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop_en    (loop_en),
        .song_sel   (song_sel),
        .note       (note),
        .note_valid (note_valid),
        .note_on    (note_on),
        .busy       (busy),
        .done       (done),
        .cur_idx    (cur_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Settle, then compare all presentation outputs for the current cycle.
    task automatic expect_o(input string tag, input int en, input int ev, input int eon,
                            input int eb, input int ed);
        #1;
        check({tag, ".note"},  32'(note),       32'(en));
        check({tag, ".valid"}, 32'(note_valid), 32'(ev));
        check({tag, ".on"},    32'(note_on),    32'(eon));
        check({tag, ".busy"},  32'(busy),       32'(eb));
        check({tag, ".done"},  32'(done),       32'(ed));
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        expect_o("rst", 0, 0, 0, 0, 0);
        check("rst.idx", 32'(cur_idx), 0);
        go();
        go();
        rst_n = 1'b1;

`ifdef SONG_GAP_EN
        // Gap build: note 1 x3, two silent gap cycles, note 5 x2, then end.
        go(); song_sel = 2'd0; start = 1'b1;
        expect_o("g.c0", 0, 0, 0, 0, 0);
        go(); start = 1'b0;
        expect_o("g.fetch", 0, 0, 0, 1, 0);
        go(); expect_o("g.n1a", 1, 1, 1, 1, 0);
        go(); expect_o("g.n1b", 1, 1, 0, 1, 0);
        go(); expect_o("g.n1c", 1, 1, 0, 1, 0);
        go(); expect_o("g.gap1", 0, 0, 0, 1, 0);
        go(); expect_o("g.gap2", 0, 0, 0, 1, 0);
        go(); expect_o("g.n5a", 5, 1, 1, 1, 0);
        check("g.idx1", 32'(cur_idx), 1);
        go(); expect_o("g.n5b", 5, 1, 0, 1, 0);
        go(); expect_o("g.done", 0, 0, 0, 1, 1);
        go(); expect_o("g.idle", 0, 0, 0, 0, 0);
`else
        // Song 0 once: start at N, notes at N+2 and N+5, done N+7, idle N+8.
        go(); song_sel = 2'd0; start = 1'b1;
        expect_o("t1.c0", 0, 0, 0, 0, 0);
        go(); start = 1'b0;
        expect_o("t1.fetch", 0, 0, 0, 1, 0);
        go(); expect_o("t1.n1a", 1, 1, 1, 1, 0);
        check("t1.idx0", 32'(cur_idx), 0);
        go(); expect_o("t1.n1b", 1, 1, 0, 1, 0);
        go(); expect_o("t1.n1c", 1, 1, 0, 1, 0);
        go(); expect_o("t1.n5a", 5, 1, 1, 1, 0);
        check("t1.idx1", 32'(cur_idx), 1);
        go(); expect_o("t1.n5b", 5, 1, 0, 1, 0);
        go(); expect_o("t1.done", 0, 0, 0, 1, 1);
        go(); expect_o("t1.idle", 0, 0, 0, 0, 0);

        // Looping: end cycle, FETCH, note 1 again; drop loop_en -> done after pass 2.
        go(); loop_en = 1'b1; start = 1'b1;
        expect_o("t2.c0", 0, 0, 0, 0, 0);
        go(); start = 1'b0;
        expect_o("t2.fetch", 0, 0, 0, 1, 0);
        go(); expect_o("t2.n1a", 1, 1, 1, 1, 0);
        go(); go();
        go(); expect_o("t2.n5a", 5, 1, 1, 1, 0);
        go();
        go(); expect_o("t2.endloop", 0, 0, 0, 1, 0);
        go(); expect_o("t2.refetch", 0, 0, 0, 1, 0);
        check("t2.refetch.idx", 32'(cur_idx), 0);
        go(); expect_o("t2.p2n1a", 1, 1, 1, 1, 0);
        go(); loop_en = 1'b0;
        expect_o("t2.p2n1b", 1, 1, 0, 1, 0);
        go();
        go(); expect_o("t2.p2n5a", 5, 1, 1, 1, 0);
        go(); expect_o("t2.p2n5b", 5, 1, 0, 1, 0);
        go(); expect_o("t2.done", 0, 0, 0, 1, 1);
        go(); expect_o("t2.idle", 0, 0, 0, 0, 0);

        // Pause 4 cycles after 3 cycles of a 10-cycle note; 7 cycles remain after.
        go(); song_sel = 2'd1; start = 1'b1;
        go(); start = 1'b0;
        expect_o("t3.fetch", 0, 0, 0, 1, 0);
        go(); expect_o("t3.n1a", 1, 1, 1, 1, 0);
        go(); go();
        expect_o("t3.n1c", 1, 1, 0, 1, 0);
        go(); pause = 1'b1;
        expect_o("t3.pause0", 0, 0, 0, 1, 0);
        for (int i = 1; i < 4; i++) begin
            go();
            expect_o($sformatf("t3.pause%0d", i), 0, 0, 0, 1, 0);
        end
        go(); pause = 1'b0;
        expect_o("t3.res0", 1, 1, 0, 1, 0);
        for (int i = 1; i < 7; i++) begin
            go();
            expect_o($sformatf("t3.res%0d", i), 1, 1, 0, 1, 0);
        end
        go(); expect_o("t3.rest", 0, 1, 1, 1, 0);
        check("t3.idx1", 32'(cur_idx), 1);

        // Stop together with pause while playing; then start with stop in IDLE.
        go(); pause = 1'b1; stop = 1'b1;
        expect_o("t4.stopcyc", 0, 0, 0, 1, 0);
        go(); pause = 1'b0; stop = 1'b0;
        expect_o("t4.idle", 0, 0, 0, 0, 0);
        check("t4.idx", 32'(cur_idx), 0);
        go(); start = 1'b1; stop = 1'b1;
        expect_o("t4.ss0", 0, 0, 0, 0, 0);
        go(); start = 1'b0; stop = 1'b0;
        expect_o("t4.ss1", 0, 0, 0, 0, 0);
        go(); expect_o("t4.ss2", 0, 0, 0, 0, 0);

        // One-cycle notes back to back.
        go(); song_sel = 2'd2; start = 1'b1;
        go(); start = 1'b0;
        expect_o("td.fetch", 0, 0, 0, 1, 0);
        go(); expect_o("td.n7", 7, 1, 1, 1, 0);
        go(); expect_o("td.n8", 8, 1, 1, 1, 0);
        go(); expect_o("td.n9", 9, 1, 1, 1, 0);
        check("td.idx2", 32'(cur_idx), 2);
        go(); expect_o("td.done", 0, 0, 0, 1, 1);
        go(); expect_o("td.idle", 0, 0, 0, 0, 0);

        // Out-of-range song: done the cycle after start, nothing presented.
        go(); song_sel = 2'd3; start = 1'b1;
        expect_o("t5.c0", 0, 0, 0, 0, 0);
        go(); start = 1'b0;
        expect_o("t5.oor", 0, 0, 0, 1, 1);
        go(); expect_o("t5.oor.idle", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a note.
        go(); song_sel = 2'd0; start = 1'b1;
        go(); start = 1'b0;
        go(); expect_o("t5.n1a", 1, 1, 1, 1, 0);
        go(); rst_n = 1'b0;
        expect_o("t5.arst", 0, 0, 0, 0, 0);
        check("t5.arst.idx", 32'(cur_idx), 0);
        go(); rst_n = 1'b1;
        expect_o("t5.arst1", 0, 0, 0, 0, 0);
        go(); expect_o("t5.arst2", 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
